// File: rtl/pal576i_timing_pkg.sv
// PAL 576i (625-line, 2:1 interlaced) frame timing constants and half-line pulse types.
// Shared by the csync encoder and the csync regenerator's plausibility checks.
package pal576i_timing_pkg;

  localparam int unsigned LINE_W = 10;

  localparam logic [LINE_W-1:0] LINES_PER_FRAME   = 10'd625;
  localparam logic [LINE_W-1:0] FIELD2_START_LINE = 10'd313;

  // Vertical blanking groups that carry broad/equalizing pulses.
  localparam logic [LINE_W-1:0] VBLANK1_FIRST = 10'd1;
  localparam logic [LINE_W-1:0] VBLANK1_LAST  = 10'd5;
  localparam logic [LINE_W-1:0] VBLANK2_FIRST = 10'd311;
  localparam logic [LINE_W-1:0] VBLANK2_LAST  = 10'd318;
  localparam logic [LINE_W-1:0] VBLANK3_FIRST = 10'd623;
  localparam logic [LINE_W-1:0] VBLANK3_LAST  = 10'd625;

  typedef enum logic [1:0] {
    PT_NONE,
    PT_NORMAL,
    PT_EQ,
    PT_BROAD
  } pulse_type_t;

  // True for any line that carries something other than a plain line-sync pulse.
  function automatic logic isVblankLine(input logic [LINE_W-1:0] line);
    return ((line >= VBLANK1_FIRST) && (line <= VBLANK1_LAST)) ||
           ((line >= VBLANK2_FIRST) && (line <= VBLANK2_LAST)) ||
           ((line >= VBLANK3_FIRST) && (line <= VBLANK3_LAST));
  endfunction

endpackage

// File: rtl/pal576i_halfline_classifier.sv
// Combinational lookup of the sync pulse type for one half-line of a 625-line frame.
module pal576i_halfline_classifier
  import pal576i_timing_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic              secondHalf,
  output pulse_type_t       pulseType
);

  // Active video lines get a line-sync in h0 only; vblank lines are decoded per group.
  always_comb begin
    pulseType = secondHalf ? PT_NONE : PT_NORMAL;
    if (isVblankLine(line)) begin
      if (line <= VBLANK1_LAST) begin
        // Field 1 start: broad, broad, broad/eq, then two eq lines.
        if (line <= 10'd2) begin
          pulseType = PT_BROAD;
        end else if (line == 10'd3) begin
          pulseType = secondHalf ? PT_EQ : PT_BROAD;
        end else begin
          pulseType = PT_EQ;
        end
      end else if (line <= VBLANK2_LAST) begin
        // Field 2 start is offset by half a line, so the groups straddle line midpoints.
        if (line <= 10'd312) begin
          pulseType = PT_EQ;
        end else if (line == FIELD2_START_LINE) begin
          pulseType = secondHalf ? PT_BROAD : PT_EQ;
        end else if (line <= 10'd315) begin
          pulseType = PT_BROAD;
        end else if (line <= 10'd317) begin
          pulseType = PT_EQ;
        end else begin
          pulseType = secondHalf ? PT_NONE : PT_EQ;
        end
      end else begin
        // Pre-equalizing ahead of field 1.
        if (line == VBLANK3_FIRST) begin
          pulseType = secondHalf ? PT_EQ : PT_NORMAL;
        end else begin
          pulseType = PT_EQ;
        end
      end
    end
  end

endmodule

// File: rtl/pal576i_csync_encoder.sv
// Free-running PAL 576i composite sync generator with hsync/vsync/field strobes.
// Counter state (lineQ, hCountQ) is decoded and registered, so outputs lag it by one clock.
module pal576i_csync_encoder
  import pal576i_timing_pkg::*;
#(
  parameter int unsigned CLKS_PER_LINE = 5184,
  parameter int unsigned HSYNC_CLKS    = 381,
  parameter int unsigned EQ_CLKS       = 190,
  parameter int unsigned SERR_CLKS     = 381
) (
  input  logic              sysClock,
  input  logic              nReset,
  input  logic              tickEn,
  input  logic              restart,
  output logic              csync,
  output logic              hsync,
  output logic              vsync,
  output logic              isFieldOdd,
  output logic [LINE_W-1:0] lineNumber
);

  localparam int unsigned HCountW = $clog2(CLKS_PER_LINE);

  localparam logic [HCountW-1:0] HalfLine = HCountW'(CLKS_PER_LINE / 2);
  localparam logic [HCountW-1:0] LastH    = HCountW'(CLKS_PER_LINE - 1);
  localparam logic [HCountW-1:0] NormalW  = HCountW'(HSYNC_CLKS);
  localparam logic [HCountW-1:0] EqW      = HCountW'(EQ_CLKS);
  localparam logic [HCountW-1:0] BroadW   = HCountW'(CLKS_PER_LINE / 2 - SERR_CLKS);

  logic [HCountW-1:0] hCountQ;
  logic [LINE_W-1:0]  lineQ;

  logic               secondHalf;
  logic [HCountW-1:0] halfOffset;
  logic [HCountW-1:0] lowWidth;
  pulse_type_t        pulseType;

  logic csyncD;
  logic hsyncD;
  logic vsyncD;
  logic fieldOddD;
  logic field1Start;
  logic field2Start;

  assign secondHalf = (hCountQ >= HalfLine);
  assign halfOffset = secondHalf ? (hCountQ - HalfLine) : hCountQ;

  pal576i_halfline_classifier uClassifier (
    .line       (lineQ),
    .secondHalf (secondHalf),
    .pulseType  (pulseType)
  );

  // Low width of the pulse that belongs to the current half-line.
  always_comb begin
    lowWidth = '0;
    unique case (pulseType)
      PT_NORMAL: lowWidth = NormalW;
      PT_EQ:     lowWidth = EqW;
      PT_BROAD:  lowWidth = BroadW;
      default:   lowWidth = '0;
    endcase
  end

  assign field1Start = (lineQ == 10'd1) && (hCountQ == '0);
  assign field2Start = (lineQ == FIELD2_START_LINE) && (hCountQ == HalfLine);

  assign csyncD    = (halfOffset >= lowWidth);
  assign hsyncD    = (hCountQ == '0);
  assign vsyncD    = field1Start || field2Start;
  // The field flag only changes on a field boundary and otherwise holds.
  assign fieldOddD = field1Start ? 1'b1 : (field2Start ? 1'b0 : isFieldOdd);

  // Horizontal and line counters; restart and reset both park at (line 1, hCount 0).
  always_ff @(posedge sysClock) begin
    if (!nReset) begin
      hCountQ <= '0;
      lineQ   <= 10'd1;
    end else if (restart) begin
      hCountQ <= '0;
      lineQ   <= 10'd1;
    end else if (tickEn) begin
      if (hCountQ == LastH) begin
        hCountQ <= '0;
        lineQ   <= (lineQ == LINES_PER_FRAME) ? 10'd1 : (lineQ + 10'd1);
      end else begin
        hCountQ <= hCountQ + HCountW'(1);
      end
    end
  end

  // Registered outputs; strobes drop whenever the counters are not advancing.
  always_ff @(posedge sysClock) begin
    if (!nReset) begin
      csync      <= 1'b1;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      isFieldOdd <= 1'b1;
      lineNumber <= 10'd1;
    end else if (restart) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (tickEn) begin
      csync      <= csyncD;
      hsync      <= hsyncD;
      vsync      <= vsyncD;
      isFieldOdd <= fieldOddD;
      lineNumber <= lineQ;
    end else begin
      hsync <= 1'b0;
      vsync <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pal576i_csync_encoder.sv
// Bench for pal576i_csync_encoder: a full-size instance and a short-line instance share
// stimulus; each is compared every cycle against a frame-position reference model.
module tb_pal576i_csync_encoder;

  localparam int TNone  = 0;
  localparam int TNorm  = 1;
  localparam int TEq    = 2;
  localparam int TBroad = 3;

  localparam logic [13:0] ResetVec = 14'b1_0_0_1_0000000001;
  localparam logic [13:0] Line1Vec = 14'b0_1_1_1_0000000001;

  logic sysClock = 1'b0;
  logic nReset;
  logic tickEn;
  logic restart;

  logic       csF, hsF, vsF, oddF;
  logic [9:0] lnF;
  logic       csS, hsS, vsS, oddS;
  logic [9:0] lnS;

  always #5 sysClock = ~sysClock;

  pal576i_csync_encoder dutFull (
    .sysClock   (sysClock),
    .nReset     (nReset),
    .tickEn     (tickEn),
    .restart    (restart),
    .csync      (csF),
    .hsync      (hsF),
    .vsync      (vsF),
    .isFieldOdd (oddF),
    .lineNumber (lnF)
  );

  pal576i_csync_encoder #(
    .CLKS_PER_LINE (64),
    .HSYNC_CLKS    (5),
    .EQ_CLKS       (3),
    .SERR_CLKS     (5)
  ) dutSmall (
    .sysClock   (sysClock),
    .nReset     (nReset),
    .tickEn     (tickEn),
    .restart    (restart),
    .csync      (csS),
    .hsync      (hsS),
    .vsync      (vsS),
    .isFieldOdd (oddS),
    .lineNumber (lnS)
  );

  // Reference model: per-line half-line types and per-instance frame position in ticks.
  int halfType [1:625][2];
  int lineLen [2] = '{5184, 64};
  int hsW     [2] = '{381, 5};
  int eqW     [2] = '{190, 3};
  int serrW   [2] = '{381, 5};
  int pos     [2];
  logic [13:0] expv [2];

  int nVectors;
  int nMiscompares;

  task automatic checkVec(input string tag, input logic [13:0] got, input logic [13:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic fillRange(input int first, input int last, input int t0, input int t1);
    for (int l = first; l <= last; l++) begin
      halfType[l][0] = t0;
      halfType[l][1] = t1;
    end
  endtask

  // Outputs for one counted tick at frame position p: {csync, hsync, vsync, odd, line}.
  function automatic logic [13:0] tickOut(input int k, input int p);
    int len;
    int half;
    int ln;
    int h;
    int hf;
    int off;
    int w;
    int fieldB;
    len    = lineLen[k];
    half   = len / 2;
    ln     = p / len + 1;
    h      = p % len;
    hf     = (h >= half) ? 1 : 0;
    off    = h - hf * half;
    fieldB = 312 * len + half;
    case (halfType[ln][hf])
      TNorm:   w = hsW[k];
      TEq:     w = eqW[k];
      TBroad:  w = half - serrW[k];
      default: w = 0;
    endcase
    return {off >= w, h == 0, (p == 0) || (p == fieldB), p < fieldB, 10'(ln)};
  endfunction

  task automatic modelEdge(input logic rn, input logic rs, input logic te);
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        pos[k]  = 0;
        expv[k] = ResetVec;
      end else if (rs) begin
        pos[k]         = 0;
        expv[k][12:11] = 2'b00;
      end else if (te) begin
        expv[k] = tickOut(k, pos[k]);
        pos[k]  = (pos[k] + 1) % (625 * lineLen[k]);
      end else begin
        expv[k][12:11] = 2'b00;
      end
    end
  endtask

  task automatic step(input logic rn, input logic rs, input logic te);
    @(negedge sysClock);
    nReset  = rn;
    restart = rs;
    tickEn  = te;
    @(posedge sysClock);
    modelEdge(rn, rs, te);
    #1;
    checkVec("full", {csF, hsF, vsF, oddF, lnF}, expv[0]);
    checkVec("small", {csS, hsS, vsS, oddS, lnS}, expv[1]);
  endtask

  initial begin
    int  lowCnt;
    int  hsCntF;
    int  hsCntS;
    int  vsCntS;
    int  freezeLeft;
    bit  froze;
    bit  reached;
    logic te;

    nVectors     = 0;
    nMiscompares = 0;
    nReset       = 1'b0;
    restart      = 1'b0;
    tickEn       = 1'b1;
    pos[0]       = 0;
    pos[1]       = 0;
    expv[0]      = ResetVec;
    expv[1]      = ResetVec;

    fillRange(1, 625, TNorm, TNone);
    fillRange(1, 2, TBroad, TBroad);
    fillRange(3, 3, TBroad, TEq);
    fillRange(4, 5, TEq, TEq);
    fillRange(311, 312, TEq, TEq);
    fillRange(313, 313, TEq, TBroad);
    fillRange(314, 315, TBroad, TBroad);
    fillRange(316, 317, TEq, TEq);
    fillRange(318, 318, TEq, TNone);
    fillRange(623, 623, TNorm, TEq);
    fillRange(624, 625, TEq, TEq);

    // Reset, including a cycle where restart is also raised.
    for (int i = 0; i < 5; i++) step(1'b0, (i == 2), 1'b1);
    checkVec("resetWinsRestart", {csF, hsF, vsF, oddF, lnF}, ResetVec);

    // Full-rate run from release: line-1 broad pulse, serration, second broad pulse.
    lowCnt = 0;
    hsCntF = 0;
    hsCntS = 0;
    vsCntS = 0;
    for (int i = 1; i <= 2700; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (i == 1) checkVec("releaseEdge1", {csF, hsF, vsF, oddF, lnF}, Line1Vec);
      if (i <= 2592 && csF == 1'b0) lowCnt++;
      if (i == 2593) checkVec("fullH1Low", 14'(csF), 14'd0);
      if (hsF) hsCntF++;
      if (hsS) hsCntS++;
      if (vsS) vsCntS++;
    end
    checkVec("line1LowRun", 14'(lowCnt), 14'd2211);
    checkVec("fullHsyncCount", 14'(hsCntF), 14'd1);
    checkVec("smallHsyncCount", 14'(hsCntS), 14'd43);
    checkVec("smallVsyncCount", 14'(vsCntS), 14'd1);

    // Long random-enable run covering a whole short frame plus its wrap, with a
    // 50-cycle freeze inside the full instance's line 5.
    froze      = 1'b0;
    freezeLeft = 0;
    for (int i = 0; i < 41000; i++) begin
      te = ($urandom_range(0, 19) != 0);
      if (!froze && pos[0] == 4 * 5184 + 100) begin
        froze      = 1'b1;
        freezeLeft = 50;
      end
      if (freezeLeft > 0) begin
        te = 1'b0;
        freezeLeft--;
      end
      step(1'b1, 1'b0, te);
    end

    // Walk the short instance to (line 200, hCount 10), then restart.
    reached = 1'b0;
    for (int i = 0; i < 20000 && !reached; i++) begin
      if (pos[1] == 199 * 64 + 10) reached = 1'b1;
      else step(1'b1, 1'b0, ($urandom_range(0, 19) != 0));
    end
    if (!reached) checkVec("reachLine200Timeout", 14'd0, 14'd1);
    checkVec("smallLine200", 14'(lnS), 14'd200);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    checkVec("restartFull", {csF, hsF, vsF, oddF, lnF}, Line1Vec);
    checkVec("restartSmall", {csS, hsS, vsS, oddS, lnS}, Line1Vec);

    // Random mix of enables, restarts and mid-frame resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 799) != 0), ($urandom_range(0, 499) == 0),
           ($urandom_range(0, 9) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
